// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types and constants for the memory copy engine.
//   state_e        - engine FSM state encoding
//   DEF_BASE_ADDR  - default byte address of RAM word 0
//   len_width()    - width of a word count that can hold 0..depth
package mem_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

  // Length must represent MEMORY_DEPTH itself, hence the extra bit.
  function automatic int len_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_copy_range_chk.sv
// mem_copy_range_chk: combinational range check of a (byte address, word
// count) pair against the RAM window starting at BASE_ADDR.
//   addr_i  - byte address of the first word
//   len_i   - number of words
//   valid_o - address is word aligned and the whole range fits in the RAM
module mem_copy_range_chk
  import mem_copy_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int                    LEN_W        = len_width(MEMORY_DEPTH)
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  valid_o
);

  localparam int SW = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] offset;
  logic [SW-1:0]         end_idx;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the bound.
  assign offset  = addr_i - BASE_ADDR;
  // One extra bit so index + length can never wrap back into range.
  assign end_idx = SW'(offset[DATA_WIDTH-1:2]) + SW'(len_i);
  assign valid_o = (offset[1:0] == 2'b00) && (end_idx <= SW'(MEMORY_DEPTH));

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-granular block copy inside a single-port data RAM.
// Each word takes one read cycle (combinational RAM read, captured at the
// edge) and one write cycle. The RAM port is driven only while busy.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start_i               - request, sampled when the engine is not busy
//   Src_Addr_i/Dst_Addr_i - source / destination byte addresses
//   Length_i              - word count 0..MEMORY_DEPTH
//   busy_o                - copy in progress
//   done_o                - one-cycle completion pulse
//   error_o               - with done_o when the request was rejected
//   Address_o, Write_Data_o, Write_en_o, Read_Data_i - RAM port
// Optional feature macro MEM_COPY_FILL_EN: adds fill_i / Fill_Data_i; a fill
// request writes Fill_Data_i to the destination range, one word per cycle.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DEF_BASE_ADDR,
  localparam int                   LEN_W        = len_width(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] Src_Addr_i,
  input  logic [DATA_WIDTH-1:0] Dst_Addr_i,
  input  logic [LEN_W-1:0]      Length_i,
`ifdef MEM_COPY_FILL_EN
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] Fill_Data_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Write_en_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [DATA_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  fill_q, fill_d;

  logic src_ok, dst_ok, fill_req, idle_like;

`ifdef MEM_COPY_FILL_EN
  assign fill_req = fill_i;
`else
  assign fill_req = 1'b0;
`endif

  mem_copy_range_chk #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .BASE_ADDR   (BASE_ADDR),
    .LEN_W       (LEN_W)
  ) u_src_chk (
    .addr_i (Src_Addr_i),
    .len_i  (Length_i),
    .valid_o(src_ok)
  );

  mem_copy_range_chk #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .BASE_ADDR   (BASE_ADDR),
    .LEN_W       (LEN_W)
  ) u_dst_chk (
    .addr_i (Dst_Addr_i),
    .len_i  (Length_i),
    .valid_o(dst_ok)
  );

  // The completion cycle also samples requests, so a new start lands on the
  // edge right after done_o without an extra idle cycle.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                     (state_q == ST_ERR);

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    fill_d    = fill_q;
    if (idle_like) begin
      state_d = ST_IDLE;
      if (start_i) begin
        // A fill never reads, so the source address is irrelevant.
        if (!dst_ok || (!fill_req && !src_ok)) begin
          state_d = ST_ERR;
        end else if (Length_i == '0) begin
          state_d = ST_DONE;
        end else begin
          src_ptr_d = Src_Addr_i;
          dst_ptr_d = Dst_Addr_i;
          cnt_d     = Length_i;
          fill_d    = fill_req;
          state_d   = ST_RD;
`ifdef MEM_COPY_FILL_EN
          if (fill_req) begin
            data_d  = Fill_Data_i;
            state_d = ST_WR;
          end
`endif
        end
      end
    end else begin
      case (state_q)
        ST_RD: begin
          data_d  = Read_Data_i;
          state_d = ST_WR;
        end
        ST_WR: begin
          src_ptr_d = src_ptr_q + DATA_WIDTH'(4);
          dst_ptr_d = dst_ptr_q + DATA_WIDTH'(4);
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
          else                    state_d = fill_q ? ST_WR : ST_RD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      fill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
    end
  end

  // Outputs decode registered state only; reset forces Write_en_o low at once.
  always_comb begin
    Address_o = BASE_ADDR;
    case (state_q)
      ST_RD:   Address_o = src_ptr_q;
      ST_WR:   Address_o = dst_ptr_q;
      default: Address_o = BASE_ADDR;
    endcase
  end

  assign Write_Data_o = data_q;
  assign Write_en_o   = (state_q == ST_WR);
  assign busy_o       = (state_q == ST_RD) || (state_q == ST_WR);
  assign done_o       = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign error_o      = (state_q == ST_ERR);

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed self-checking bench for mem_copy_engine with
// a behavioural RAM (combinational read, synchronous write).
module tb_mem_copy_engine;

  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] src_addr = '0, dst_addr = '0;
  logic [6:0]    length = '0;
  logic          busy_o, done_o, error_o, we;
  logic [DW-1:0] addr_o, wdata, rdata;
`ifdef MEM_COPY_FILL_EN
  logic          fill_i = 1'b0;
  logic [DW-1:0] fill_data = '0;
`endif

  logic [31:0] mem [0:DEPTH-1];
  int          wr_cnt = 0;
  int          total = 0, bad = 0;

  mem_copy_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .Src_Addr_i  (src_addr),
    .Dst_Addr_i  (dst_addr),
    .Length_i    (length),
`ifdef MEM_COPY_FILL_EN
    .fill_i      (fill_i),
    .Fill_Data_i (fill_data),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .Address_o   (addr_o),
    .Write_Data_o(wdata),
    .Write_en_o  (we),
    .Read_Data_i (rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram_off;
  always_comb begin
    ram_off = addr_o - BASE;
    rdata   = (ram_off[31:2] < 30'(DEPTH)) ? mem[ram_off[7:2]] : 32'h0;
  end

  always @(posedge clk) begin
    if (we) begin
      mem[ram_off[7:2]] <= wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Issue one request; done_edge counts edges after the sampling edge (edge 0).
  task automatic run_req(input logic [31:0] src, input logic [31:0] dst,
                         input logic [6:0] len, input logic fl,
                         output int done_edge, output int busy_cyc,
                         output logic err, output int writes);
    int w0;
    @(negedge clk);
    src_addr = src; dst_addr = dst; length = len; start_i = 1'b1;
`ifdef MEM_COPY_FILL_EN
    fill_i = fl;
`endif
    w0 = wr_cnt;
    done_edge = -1; busy_cyc = 0; err = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o) busy_cyc++;
      if (done_o) begin
        done_edge = k; err = error_o;
        break;
      end
      @(posedge clk);
    end
    if (done_edge < 0) chk("done_timeout", 32'(done_edge), 32'd0);
    writes = wr_cnt - w0;
`ifdef MEM_COPY_FILL_EN
    fill_i = 1'b0;
`endif
    if (fl) ; // fill flag has no effect without the fill build
  endtask

  initial begin
    int   de, bc, wn, w0;
    logic er;
    logic [3:0] busy_a, done_a;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
    mem[4] = 32'hB4; mem[5] = 32'hB5;
    mem[40] = 32'hC0; mem[41] = 32'hC1;

    // Reset values
    #1;
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_done",  32'(done_o),  32'd0);
    chk("rst_err",   32'(error_o), 32'd0);
    chk("rst_we",    32'(we),      32'd0);
    chk("rst_addr",  addr_o,       BASE);
    chk("rst_wdata", wdata,        32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic 4-word copy: words 0..3 -> 16..19
    run_req(BASE, BASE + 32'h40, 7'd4, 1'b0, de, bc, er, wn);
    chk("cp_done_edge", 32'(de), 32'd8);
    chk("cp_busy",      32'(bc), 32'd8);
    chk("cp_err",       32'(er), 32'd0);
    chk("cp_writes",    32'(wn), 32'd4);
    for (int i = 0; i < 4; i++) chk("cp_data", mem[16+i], 32'hA0 + 32'(i));

    // Zero length
    run_req(BASE, BASE + 32'h40, 7'd0, 1'b0, de, bc, er, wn);
    chk("l0_done_edge", 32'(de), 32'd0);
    chk("l0_err",       32'(er), 32'd0);
    chk("l0_writes",    32'(wn), 32'd0);
    chk("l0_busy",      32'(bc), 32'd0);

    // Misaligned source
    run_req(BASE + 32'h2, BASE + 32'h40, 7'd1, 1'b0, de, bc, er, wn);
    chk("mis_done_edge", 32'(de), 32'd0);
    chk("mis_err",       32'(er), 32'd1);
    chk("mis_writes",    32'(wn), 32'd0);

    // Source below the RAM window
    run_req(BASE - 32'h4, BASE + 32'h40, 7'd1, 1'b0, de, bc, er, wn);
    chk("low_err",    32'(er), 32'd1);
    chk("low_writes", 32'(wn), 32'd0);

    // Destination overflow (62 + 3 > 64), then exact fit (62 + 2 == 64)
    run_req(BASE, BASE + 32'hF8, 7'd3, 1'b0, de, bc, er, wn);
    chk("ovf_err",    32'(er), 32'd1);
    chk("ovf_writes", 32'(wn), 32'd0);
    chk("ovf_w62",    mem[62], 32'd0);
    run_req(BASE, BASE + 32'hF8, 7'd2, 1'b0, de, bc, er, wn);
    chk("fit_err",       32'(er), 32'd0);
    chk("fit_done_edge", 32'(de), 32'd4);
    chk("fit_w62",       mem[62], 32'hA0);
    chk("fit_w63",       mem[63], 32'hA1);

    // Overlapping ascending copy: word 40 -> 41,42 propagates C0
    run_req(BASE + 32'hA0, BASE + 32'hA4, 7'd2, 1'b0, de, bc, er, wn);
    chk("ovl_w41", mem[41], 32'hC0);
    chk("ovl_w42", mem[42], 32'hC0);

    // start_i held high through a 2-word copy (words 4,5 -> 24,25)
    @(negedge clk);
    src_addr = BASE + 32'h10; dst_addr = BASE + 32'h60; length = 7'd2;
    start_i = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      busy_a[k] = busy_o; done_a[k] = done_o;
      @(posedge clk);
    end
    @(negedge clk);  // cycle after edge 4
    chk("hold_busy_a", 32'(busy_a), 32'hF);
    chk("hold_done_a", 32'(done_a), 32'h0);
    chk("hold_done4",  32'(done_o), 32'd1);
    chk("hold_wr4",    32'(wr_cnt - w0), 32'd2);
    @(posedge clk);
    @(negedge clk);  // cycle after edge 5: second request accepted
    chk("hold_busy5", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    de = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (done_o) begin de = k; break; end
    end
    chk("hold_2nd_done", 32'(de), 32'd3);
    chk("hold_writes",   32'(wr_cnt - w0), 32'd4);
    chk("hold_w24",      mem[24], 32'hB4);
    chk("hold_w25",      mem[25], 32'hB5);

`ifdef MEM_COPY_FILL_EN
    // Fill 3 words at word 32; source deliberately misaligned (not checked)
    fill_data = 32'hDEADBEEF;
    run_req(BASE + 32'h3, BASE + 32'h80, 7'd3, 1'b1, de, bc, er, wn);
    chk("fill_done_edge", 32'(de), 32'd3);
    chk("fill_busy",      32'(bc), 32'd3);
    chk("fill_err",       32'(er), 32'd0);
    chk("fill_writes",    32'(wn), 32'd3);
    for (int i = 0; i < 3; i++) chk("fill_data", mem[32+i], 32'hDEADBEEF);
`endif

    // Asynchronous reset during the second WR of a copy to word 48
    @(negedge clk);
    src_addr = BASE; dst_addr = BASE + 32'hC0; length = 7'd4; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0;   // RD
    @(posedge clk); @(negedge clk);   // WR word 48
    @(posedge clk); @(negedge clk);   // RD
    @(posedge clk); @(negedge clk);   // WR word 49
    chk("mid_we_before", 32'(we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we_after", 32'(we),     32'd0);
    chk("mid_busy",     32'(busy_o), 32'd0);
    chk("mid_done",     32'(done_o), 32'd0);
    chk("mid_addr",     addr_o,      BASE);
    @(negedge clk);
    rst_n = 1'b1;
    er = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) er = 1'b1;
    end
    chk("mid_no_done", 32'(er),  32'd0);
    chk("mid_w48",     mem[48], 32'hA0);
    chk("mid_w49",     mem[49], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
